lv1_bus_master: RTL
===================

# lv1_bus_master

Per-core Level-1 bus master sitting directly upstream of the L1/L2 bus arbiter. It buffers bus commands from one L1 cache controller and drives that core's `bus_lv1_lv2_req_proc` bit. It waits for the matching grant, drives the command onto the shared L1/L2 bus and holds the request until the transaction completes. It then releases the bus for a guaranteed idle gap so the arbiter can re-arbitrate. Four instances, one per core, feed the arbiter's 4-bit request vector.

## Interface
Parameters:
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data width
- `FIFO_DEPTH`, 2, command buffer entries (power of two, ≥2)
- `GNT_TIMEOUT`, 64, cycles in REQ before a timeout error
- `MIN_GAP`, 1, cycles the request is held low after each transaction (≥1)

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command push handshake from the L1 controller.
- `cmd_op` in 2: `bus_op_t`.
- `cmd_addr` in ADDR_W.
- `cmd_wdata` in DATA_W: used by `BUS_WB` only.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out DATA_W.
- `rsp_shared` out 1.
- `bus_lv1_lv2_req_proc` out 1: to the arbiter's request bit for this core.
- `bus_lv1_lv2_gnt_proc` in 1: from the arbiter's grant bit for this core.
- `bus_drive_en` out 1: high while this core owns and drives the bus.
- `bus_op_out` out 2, `bus_addr_out` out ADDR_W, `bus_data_out` out DATA_W: zero when `bus_drive_en` is low.
- `bus_done` in 1: transaction complete, from L2 or a snooper.
- `bus_rdata` in DATA_W, `bus_shared` in 1: sampled when `bus_done` is seen.
- `err_gnt_timeout` out 1, `err_gnt_lost` out 1: sticky error flags, cleared only by `rst`.

## Operation
- FIFO: push on `cmd_valid & cmd_ready`; `cmd_ready = !full`. Pop happens on the same edge the FSM leaves XFER via done. Simultaneous push and pop when full is not allowed, because ready is low.
- FSM states:
  - IDLE → REQ when the FIFO is non-empty.
  - REQ: `req_proc`=1. Go to XFER on the edge where `gnt_proc`=1.
  - XFER: `req_proc`=1 and `bus_drive_en`=1. Drive the FIFO-head op, address and data.
  - RELEASE: `req_proc`=0 for exactly MIN_GAP cycles, then go to REQ if the FIFO is non-empty, else IDLE.
- Leaving XFER via `bus_done`=1:
  - capture `bus_rdata` and `bus_shared` into `rsp_data`/`rsp_shared`, and pulse `rsp_valid` in the following cycle;
  - pop the FIFO;
  - go to RELEASE.
- Grant lost in XFER (`gnt_proc`=0 and `bus_done`=0): set `err_gnt_lost`, do not pop, go to RELEASE, then retry the same command.
- `bus_done` is ignored outside XFER.
- Grant timeout: a counter runs while in REQ and resets on exit. When it reaches GNT_TIMEOUT, set `err_gnt_timeout` and stay in REQ; the request is never withdrawn.
- `rsp_data` and `rsp_shared` hold their value until the next completion.

## Timing
- Reset values:
  - every output is 0, except `cmd_ready`=1;
  - FIFO empty, FSM in IDLE, counters 0.
- Reset mid-transaction: `req_proc` and `bus_drive_en` are low from the first edge after `rst` is sampled; in-flight and buffered commands are discarded with no `rsp_valid`.
- Push at edge k into an empty FIFO while in IDLE: `req_proc` goes high after edge k+1.
- `gnt_proc` sampled high at edge g: `bus_drive_en` goes high after g, so the bus is driven from cycle g+1.
- `bus_done` sampled at edge d:
  - `req_proc` and `bus_drive_en` go low after d;
  - `rsp_valid` is high during cycle d+1;
  - `cmd_ready` reflects the freed slot after d.
- Minimum back-to-back: next `req_proc` rise after edge d+MIN_GAP. MIN_GAP=1 satisfies the arbiter's requirement of one low cycle to clear its held grant.
- The FIFO-head fields must be stable throughout XFER; there is no combinational path from `bus_done` to `bus_*_out`.

## Structure
- Shared package `lv1_lv2_bus_pkg` holds:
  - `bus_op_t` enum: `BUS_RD`=0, `BUS_RDX`=1, `BUS_INV`=2, `BUS_WB`=3;
  - `lv1_bus_state_t`: IDLE, REQ, XFER, RELEASE;
  - a packed command struct {op, addr, wdata}.
- One sub-module: `lv1_bus_cmd_fifo`, a synchronous FIFO of command structs with full and empty flags, parameterised on depth.
- The FSM, timeout counter and gap counter live in the top module.

## Test plan
- Single read: push `BUS_RD`, addr 0x100. Arbiter grants 2 cycles after `req_proc` rises, `bus_done` 3 cycles into XFER with `bus_rdata`=0xDEADBEEF and `bus_shared`=1. Expect:
  - one `rsp_valid` pulse with 0xDEADBEEF and shared=1;
  - `req_proc` low for exactly 1 cycle afterwards.
- Back-to-back: push 3 commands with FIFO_DEPTH=2. Expect:
  - `cmd_ready` low after the second push until the first completion;
  - three responses in order;
  - a `req_proc` low gap of MIN_GAP between each transaction.
- Timeout: hold `gnt_proc`=0 for 70 cycles. Expect:
  - `err_gnt_timeout` set at cycle 64 of REQ;
  - `req_proc` stays high;
  - a later grant completes normally.
- Grant lost: drop `gnt_proc` mid-XFER with no done. Expect:
  - `err_gnt_lost`=1;
  - a 1-cycle release, then re-request;
  - the same address re-driven and a single `rsp_valid` on the eventual done.
- Reset mid-XFER: assert `rst` for 1 cycle while `bus_drive_en`=1. Expect:
  - all outputs 0 on the next cycle, `cmd_ready`=1;
  - no `rsp_valid`;
  - FIFO empty.
- Spurious done: pulse `bus_done` in IDLE and in REQ. Expect no `rsp_valid` and no FIFO pop.

Source files
------------

// File: rtl/lv1_lv2_bus_pkg.sv
// Shared L1/L2 bus definitions: bus operation codes, the per-core bus master
// state type and the packed command word buffered by each master.
package lv1_lv2_bus_pkg;

  // Widths of the buffered command fields. Masters with narrower buses
  // zero-extend into these fields and truncate on the way out.
  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    BUS_RD  = 2'd0,
    BUS_RDX = 2'd1,
    BUS_INV = 2'd2,
    BUS_WB  = 2'd3
  } bus_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    RELEASE
  } lv1_bus_state_t;

  typedef struct packed {
    bus_op_t                 op;
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
  } bus_cmd_t;

endpackage

// File: rtl/lv1_bus_master_if.sv
// Signal bundle between one L1 cache controller, its bus master and the
// L1/L2 bus / arbiter.
//   command side : cmd_valid/cmd_ready handshake, cmd_op, cmd_addr, cmd_wdata
//   response side: rsp_valid pulse, rsp_data, rsp_shared
//   arbiter      : bus_lv1_lv2_req_proc (out), bus_lv1_lv2_gnt_proc (in)
//   shared bus   : bus_drive_en, bus_op_out, bus_addr_out, bus_data_out,
//                  bus_done, bus_rdata, bus_shared
//   errors       : err_gnt_timeout, err_gnt_lost (sticky)
// modport master = the bus master's view, modport slave = its environment.
interface lv1_bus_master_if
  import lv1_lv2_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              cmd_valid;
  logic              cmd_ready;
  bus_op_t           cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_shared;
  logic              bus_lv1_lv2_req_proc;
  logic              bus_lv1_lv2_gnt_proc;
  logic              bus_drive_en;
  bus_op_t           bus_op_out;
  logic [ADDR_W-1:0] bus_addr_out;
  logic [DATA_W-1:0] bus_data_out;
  logic              bus_done;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_shared;
  logic              err_gnt_timeout;
  logic              err_gnt_lost;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
           bus_lv1_lv2_gnt_proc, bus_done, bus_rdata, bus_shared,
    output cmd_ready, rsp_valid, rsp_data, rsp_shared,
           bus_lv1_lv2_req_proc, bus_drive_en, bus_op_out, bus_addr_out,
           bus_data_out, err_gnt_timeout, err_gnt_lost
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
           bus_lv1_lv2_gnt_proc, bus_done, bus_rdata, bus_shared,
    input  cmd_ready, rsp_valid, rsp_data, rsp_shared,
           bus_lv1_lv2_req_proc, bus_drive_en, bus_op_out, bus_addr_out,
           bus_data_out, err_gnt_timeout, err_gnt_lost
  );

endinterface

// File: rtl/lv1_bus_cmd_fifo.sv
// Synchronous FIFO of bus command words.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  : write a command (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   head         : current head entry, valid while !empty
//   full, empty  : occupancy flags
module lv1_bus_cmd_fifo
  import lv1_lv2_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  bus_cmd_t wdata,
  output bus_cmd_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  bus_cmd_t         mem [DEPTH];
  // One extra wrap bit distinguishes full from empty.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr[PTR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/lv1_bus_master.sv
// Per-core L1 bus master. Buffers commands from the L1 controller, requests
// the L1/L2 bus from the arbiter, drives the head command while granted,
// returns the response and then drops the request for MIN_GAP cycles so the
// arbiter can re-arbitrate.
//   clk, rst : clock, synchronous active-high reset
//   bus      : lv1_bus_master_if.master (command, response, arbiter, bus,
//              error signals)
module lv1_bus_master
  import lv1_lv2_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned GNT_TIMEOUT = 64,
  parameter int unsigned MIN_GAP     = 1
) (
  input  logic                clk,
  input  logic                rst,
  lv1_bus_master_if.master    bus
);

  localparam int unsigned TO_W  = $clog2(GNT_TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

  lv1_bus_state_t    state;
  lv1_bus_state_t    state_next;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  bus_cmd_t          cmd_in;
  bus_cmd_t          head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              done_xfer;
  logic              lost_xfer;
  logic              gap_done;
  logic              to_hit;
  logic              req;
  logic              drive;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_shared_q;
  logic              err_to_q;
  logic              err_lost_q;

  assign cmd_in = '{op:    bus.cmd_op,
                    addr:  BUS_ADDR_W'(bus.cmd_addr),
                    wdata: BUS_DATA_W'(bus.cmd_wdata)};
  assign push   = bus.cmd_valid && !fifo_full;

  lv1_bus_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (done_xfer),
    .wdata (cmd_in),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // done wins over a simultaneous grant drop: the transaction completed.
  assign done_xfer = (state == XFER) && bus.bus_done;
  assign lost_xfer = (state == XFER) && !bus.bus_done && !bus.bus_lv1_lv2_gnt_proc;
  assign gap_done  = (gap_cnt == GAP_W'(MIN_GAP - 1));
  assign to_hit    = (state == REQ) && !bus.bus_lv1_lv2_gnt_proc &&
                     (to_cnt == TO_W'(GNT_TIMEOUT - 1));

  always_comb begin
    state_next = state;
    req        = 1'b0;
    drive      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) state_next = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (bus.bus_lv1_lv2_gnt_proc) state_next = XFER;
      end
      XFER: begin
        req   = 1'b1;
        drive = 1'b1;
        if (bus.bus_done || !bus.bus_lv1_lv2_gnt_proc) state_next = RELEASE;
      end
      RELEASE: begin
        // fifo_empty already reflects the pop done on entry.
        if (gap_done) state_next = fifo_empty ? IDLE : REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      gap_cnt      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_shared_q <= 1'b0;
      err_to_q     <= 1'b0;
      err_lost_q   <= 1'b0;
    end else begin
      state       <= state_next;
      rsp_valid_q <= done_xfer;
      if (done_xfer) begin
        rsp_data_q   <= bus.bus_rdata;
        rsp_shared_q <= bus.bus_shared;
      end
      if (to_hit)    err_to_q   <= 1'b1;
      if (lost_xfer) err_lost_q <= 1'b1;

      // Counts edges spent waiting in REQ; saturates so the flag stays set
      // and the request is never withdrawn.
      if ((state == REQ) && (state_next == REQ)) begin
        if (to_cnt != TO_W'(GNT_TIMEOUT)) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end

      if ((state == RELEASE) && !gap_done) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign bus.cmd_ready            = !fifo_full;
  assign bus.rsp_valid            = rsp_valid_q;
  assign bus.rsp_data             = rsp_data_q;
  assign bus.rsp_shared           = rsp_shared_q;
  assign bus.bus_lv1_lv2_req_proc = req;
  assign bus.bus_drive_en         = drive;
  assign bus.bus_op_out           = drive ? head.op : BUS_RD;
  assign bus.bus_addr_out         = drive ? head.addr[ADDR_W-1:0] : '0;
  assign bus.bus_data_out         = drive ? head.wdata[DATA_W-1:0] : '0;
  assign bus.err_gnt_timeout      = err_to_q;
  assign bus.err_gnt_lost         = err_lost_q;

endmodule
